// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file read over a single port in two cycles,
// presenting A, B and a latched shift code to the shifter/ALU stage.
module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  rn,
   input  logic [2:0]  rm,
   input  logic [1:0]  shift_in,
   input  logic        write,
   input  logic [2:0]  writenum,
   input  logic [15:0] data_in,
   output logic [15:0] a_out,
   output logic [15:0] b_out,
   output logic [1:0]  shift_out,
   output logic        valid,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

   state_t      state_reg;
   logic [15:0] regs_reg [8];
   logic [2:0]  rn_reg;
   logic [2:0]  rm_reg;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [1:0]  shift_reg;
   logic        valid_reg;
   logic        busy_reg;
   logic [2:0]  rd_idx;

   assign rd_idx = (state_reg == LOAD_B) ? rm_reg : rn_reg;

   // Write port: reads elsewhere see the pre-write contents in the same cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (reset)
            regs_reg[i] <= 16'h0000;
         else if (write && (writenum == 3'(i)))
            regs_reg[i] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         rn_reg    <= 3'd0;
         rm_reg    <= 3'd0;
         a_reg     <= 16'h0000;
         b_reg     <= 16'h0000;
         shift_reg <= 2'b00;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rn_reg    <= rn;
                  rm_reg    <= rm;
                  shift_reg <= shift_in;
                  busy_reg  <= 1'b1;
                  state_reg <= LOAD_A;
               end
            end
            LOAD_A: begin
               a_reg     <= regs_reg[rd_idx];
               state_reg <= LOAD_B;
            end
            LOAD_B: begin
               b_reg     <= regs_reg[rd_idx];
               valid_reg <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign a_out     = a_reg;
   assign b_out     = b_reg;
   assign shift_out = shift_reg;
   assign valid     = valid_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// compared against an edge-indexed behavioural model.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  rn = 3'd0;
   logic [2:0]  rm = 3'd0;
   logic [1:0]  shift_in = 2'b00;
   logic        write = 1'b0;
   logic [2:0]  writenum = 3'd0;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] a_out;
   logic [15:0] b_out;
   logic [1:0]  shift_out;
   logic        valid;
   logic        busy;

   int total = 0;
   int bad = 0;

   operand_fetch dut (
      .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm),
      .shift_in(shift_in), .write(write), .writenum(writenum), .data_in(data_in),
      .a_out(a_out), .b_out(b_out), .shift_out(shift_out), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model: a fetch accepted at edge 'acc' reads A at acc+1, B at acc+2,
   // is busy after edges acc..acc+2 and valid only after edge acc+2.
   logic [15:0] m_regs [8];
   logic [15:0] m_a, m_b;
   logic [1:0]  m_sh;
   logic [2:0]  m_rn, m_rm;
   int          edge_cnt = 0;
   int          acc = -100;

   function automatic logic exp_busy();
      return (edge_cnt - acc >= 0) && (edge_cnt - acc <= 2);
   endfunction

   function automatic logic exp_valid();
      return (edge_cnt - acc) == 2;
   endfunction

   function automatic logic [15:0] shifter(input logic [15:0] v, input logic [1:0] s);
      case (s)
         2'b01:   return {v[14:0], 1'b0};
         2'b10:   return {1'b0, v[15:1]};
         2'b11:   return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

   task automatic step(input logic rst, input logic st, input logic [2:0] n, input logic [2:0] m,
                       input logic [1:0] sh, input logic w, input logic [2:0] wn,
                       input logic [15:0] d);
      int rel;
      reset = rst; start = st; rn = n; rm = m; shift_in = sh;
      write = w; writenum = wn; data_in = d;
      @(posedge clk);
      edge_cnt++;
      rel = edge_cnt - acc;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_a = 16'h0000; m_b = 16'h0000; m_sh = 2'b00; m_rn = 3'd0; m_rm = 3'd0;
         acc = -100;
      end else begin
         if (rel == 1) m_a = m_regs[m_rn];
         if (rel == 2) m_b = m_regs[m_rm];
         if (st && !(rel >= 1 && rel <= 3)) begin
            acc = edge_cnt; m_rn = n; m_rm = m; m_sh = sh;
         end
         if (w) m_regs[wn] = d;
      end
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 16'h0000);
   endtask

   task automatic wr(input logic [2:0] wn, input logic [15:0] d);
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, wn, d);
   endtask

   task automatic go(input logic [2:0] n, input logic [2:0] m, input logic [1:0] sh);
      step(1'b0, 1'b1, n, m, sh, 1'b0, 3'd0, 16'h0000);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 16'h0000);
      total++;
      if ({a_out, b_out, shift_out, valid, busy} !== 35'd0) begin
         bad++;
         $display("FAIL reset_outputs: got a=%h b=%h sh=%b v=%b busy=%b want all 0",
                  a_out, b_out, shift_out, valid, busy);
      end
      go(3'd3, 3'd5, 2'b00);
      idle_step(); idle_step();
      total++;
      if (valid !== 1'b1 || a_out !== 16'h0000 || b_out !== 16'h0000) begin
         bad++;
         $display("FAIL reset_fetch: got v=%b a=%h b=%h want v=1 a=0000 b=0000", valid, a_out, b_out);
      end
      idle_step();
   endtask

   task automatic test_basic();
      wr(3'd2, 16'h1234);
      wr(3'd7, 16'hF0CF);
      go(3'd2, 3'd7, 2'b11);
      total++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_accept: got busy=%b v=%b want busy=1 v=0", busy, valid);
      end
      idle_step();
      total++;
      if (valid !== 1'b0 || a_out !== 16'h1234) begin
         bad++;
         $display("FAIL basic_loada: got v=%b a=%h want v=0 a=1234", valid, a_out);
      end
      idle_step();
      total++;
      if (valid !== 1'b1 || a_out !== 16'h1234 || b_out !== 16'hF0CF || shift_out !== 2'b11) begin
         bad++;
         $display("FAIL basic_done: got v=%b a=%h b=%h sh=%b want v=1 a=1234 b=f0cf sh=11",
                  valid, a_out, b_out, shift_out);
      end
      total++;
      if (shifter(b_out, shift_out) !== 16'hF867) begin
         bad++;
         $display("FAIL basic_sout: got %h want f867", shifter(b_out, shift_out));
      end
      idle_step();
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_end: got v=%b busy=%b want 0 0", valid, busy);
      end
   endtask

   task automatic test_hazard();
      wr(3'd1, 16'h0001);
      wr(3'd4, 16'h0004);
      go(3'd1, 3'd4, 2'b00);
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd4, 16'hBBBB);
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd1, 16'hAAAA);
      total++;
      if (valid !== 1'b1 || a_out !== 16'h0001 || b_out !== 16'hBBBB) begin
         bad++;
         $display("FAIL hazard_b_sees: got v=%b a=%h b=%h want v=1 a=0001 b=bbbb", valid, a_out, b_out);
      end
      idle_step();
      // Write to Rn landing with the A read, write to Rm landing with the B read: both missed.
      wr(3'd3, 16'h3333);
      go(3'd3, 3'd3, 2'b00);
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd3, 16'h4444);
      step(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd3, 16'h5555);
      total++;
      if (a_out !== 16'h3333 || b_out !== 16'h4444) begin
         bad++;
         $display("FAIL hazard_edges: got a=%h b=%h want a=3333 b=4444", a_out, b_out);
      end
      idle_step();
   endtask

   task automatic test_start_busy();
      int pulses = 0;
      wr(3'd0, 16'hDEAD);
      wr(3'd5, 16'h0505);
      wr(3'd6, 16'h0606);
      go(3'd5, 3'd6, 2'b10);
      for (int i = 0; i < 3; i++) begin
         go(3'd0, 3'd0, 2'b01);
         if (valid) pulses++;
      end
      for (int i = 0; i < 5; i++) begin
         idle_step();
         if (valid) pulses++;
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL busy_pulses: got %0d valid pulses want 1", pulses);
      end
      total++;
      if (a_out !== 16'h0505 || b_out !== 16'h0606 || shift_out !== 2'b10) begin
         bad++;
         $display("FAIL busy_operands: got a=%h b=%h sh=%b want a=0505 b=0606 sh=10",
                  a_out, b_out, shift_out);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      wr(3'd5, 16'h7777);
      go(3'd5, 3'd5, 2'b01);
      idle_step();
      step(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 16'h0000);
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || a_out !== 16'h0000 || b_out !== 16'h0000 ||
          shift_out !== 2'b00) begin
         bad++;
         $display("FAIL midreset_state: got busy=%b v=%b a=%h b=%h sh=%b want all 0",
                  busy, valid, a_out, b_out, shift_out);
      end
      for (int i = 0; i < 3; i++) begin
         idle_step();
         if (valid) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL midreset_novalid: got %0d valid pulses want 0", pulses);
      end
      go(3'd5, 3'd0, 2'b00);
      idle_step(); idle_step();
      total++;
      if (a_out !== 16'h0000 || b_out !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_regs: got a=%h b=%h want 0000 0000", a_out, b_out);
      end
      idle_step();
   endtask

   task automatic test_back_to_back();
      int first_v = -1;
      int second_v = -1;
      wr(3'd6, 16'h8001);
      go(3'd6, 3'd6, 2'b00);
      idle_step(); idle_step();
      if (valid) first_v = edge_cnt;
      total++;
      if (a_out !== 16'h8001 || b_out !== 16'h8001) begin
         bad++;
         $display("FAIL b2b_same: got a=%h b=%h want 8001 8001", a_out, b_out);
      end
      idle_step();
      go(3'd6, 3'd6, 2'b01);
      idle_step(); idle_step();
      if (valid) second_v = edge_cnt;
      total++;
      if (first_v < 0 || second_v - first_v != 4) begin
         bad++;
         $display("FAIL b2b_spacing: got first=%0d second=%0d want spacing 4", first_v, second_v);
      end
      total++;
      if (shift_out !== 2'b01 || shifter(b_out, shift_out) !== 16'h0002) begin
         bad++;
         $display("FAIL b2b_sout: got sh=%b sout=%h want sh=01 sout=0002",
                  shift_out, shifter(b_out, shift_out));
      end
      idle_step();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom));
         total++;
         if (valid !== exp_valid() || busy !== exp_busy() || a_out !== m_a ||
             b_out !== m_b || shift_out !== m_sh) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle%0d: got v=%b busy=%b a=%h b=%h sh=%b want v=%b busy=%b a=%h b=%h sh=%b",
                        i, valid, busy, a_out, b_out, shift_out,
                        exp_valid(), exp_busy(), m_a, m_b, m_sh);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hazard();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
